memory_arbiter: RTL and testbench

Round-robin arbiter that shares one word-wide memory port among `NUM_PORTS` cache-side requesters (instruction and data caches of all cores). It sits between the per-core cache miss/write-through interfaces and the single memory/bus interface. It grants one requester at a time and holds the grant for the requester's whole transaction, including a 4-beat block refill. It forwards that requester's request to memory and routes `mem_ready` back only to the owner.

---
 rtl/memory_arbiter.sv | 105 ++++++++++
 tb/tb_memory_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port among NUM_PORTS cache requesters.
// The owner keeps the grant for its whole transaction; only the owner sees mem_ready.
module memory_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int PORT_ID_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_PORTS-1:0]      port_request,
  input  logic [NUM_PORTS*32-1:0]   port_address,
  input  logic [NUM_PORTS*32-1:0]   port_write_data,
  input  logic [NUM_PORTS*4-1:0]    port_byte_enable,
  input  logic [NUM_PORTS-1:0]      port_write_enable,
  output logic [NUM_PORTS-1:0]      port_ready,
  output logic [31:0]               port_read_data,
  output logic                      mem_request,
  output logic [31:0]               mem_address,
  output logic [31:0]               mem_write_data,
  output logic [3:0]                mem_byte_enable,
  output logic                      mem_write_enable,
  input  logic [31:0]               mem_read_data,
  input  logic                      mem_ready,
  output logic                      grant_valid,
  output logic [PORT_ID_BITS-1:0]   grant_id
);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                  state, state_next;
  logic [PORT_ID_BITS-1:0] owner, owner_next;
  logic [PORT_ID_BITS-1:0] rr_ptr, rr_ptr_next;
  logic [PORT_ID_BITS-1:0] pick_id, cand;
  logic                    found;
  logic                    owner_active;

  // First requesting port at or above rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    found   = 1'b0;
    pick_id = rr_ptr;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PORT_ID_BITS'((32'(rr_ptr) + i) % NUM_PORTS);
      if (!found && port_request[cand]) begin
        found   = 1'b1;
        pick_id = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next  = state;
    owner_next  = owner;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = GRANTED;
          owner_next = pick_id;
        end
      end
      GRANTED: begin
        if (!port_request[owner]) begin
          state_next  = IDLE;
          rr_ptr_next = (owner == PORT_ID_BITS'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign owner_active = (state == GRANTED) && port_request[owner];

  always_comb begin
    mem_request      = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_byte_enable  = '0;
    mem_write_enable = 1'b0;
    port_ready       = '0;
    port_read_data   = mem_read_data;
    grant_valid      = (state == GRANTED);
    grant_id         = owner;
    if (owner_active) begin
      mem_request       = 1'b1;
      mem_address       = port_address[{owner, 5'd0} +: 32];
      mem_write_data    = port_write_data[{owner, 5'd0} +: 32];
      mem_byte_enable   = port_byte_enable[{owner, 2'd0} +: 4];
      mem_write_enable  = port_write_enable[owner];
      port_ready[owner] = mem_ready;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: beats are pushed to a scoreboard when mem_ready is driven
// and popped when the arbiter returns port_ready.
module tb_memory_arbiter;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   port_request;
  logic [NP*32-1:0] port_address;
  logic [NP*32-1:0] port_write_data;
  logic [NP*4-1:0] port_byte_enable;
  logic [NP-1:0]   port_write_enable;
  logic [NP-1:0]   port_ready;
  logic [31:0]     port_read_data;
  logic            mem_request;
  logic [31:0]     mem_address;
  logic [31:0]     mem_write_data;
  logic [3:0]      mem_byte_enable;
  logic            mem_write_enable;
  logic [31:0]     mem_read_data;
  logic            mem_ready;
  logic            grant_valid;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  memory_arbiter #(.NUM_PORTS(NP), .PORT_ID_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .port_request(port_request), .port_address(port_address),
    .port_write_data(port_write_data), .port_byte_enable(port_byte_enable),
    .port_write_enable(port_write_enable), .port_ready(port_ready),
    .port_read_data(port_read_data), .mem_request(mem_request),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  typedef struct packed {
    logic [3:0]  ready;
    logic [31:0] addr;
    logic [31:0] rdata;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  task automatic sb_check();
    beat_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("beat_ready", 32'(port_ready), 32'(e.ready));
      chk("beat_addr", mem_address, e.addr);
      chk("beat_rdata", port_read_data, e.rdata);
    end else if (port_ready != '0) begin
      chk("spurious_ready", 32'(port_ready), 32'd0);
    end
  endtask

  task automatic settle();
    #1;
    sb_check();
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic we);
    port_address[32*p +: 32]    = a;
    port_write_data[32*p +: 32] = wd;
    port_byte_enable[4*p +: 4]  = be;
    port_write_enable[p]        = we;
  endtask

  // Zero-wait memory model: read data is a fixed function of the address.
  task automatic beat(input int p, input logic [31:0] a);
    mem_ready     = 1'b1;
    mem_read_data = a ^ 32'h5A5A_0000;
    sb.push_back('{ready: 4'(1 << p), addr: a, rdata: a ^ 32'h5A5A_0000});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_request"}, 32'(mem_request), 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'd0);
    chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_byte_enable), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_write_enable), 32'd0);
    chk({tag, "_port_ready"}, 32'(port_ready), 32'd0);
    chk({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    port_request      = '0;
    port_address      = '0;
    port_write_data   = '0;
    port_byte_enable  = '0;
    port_write_enable = '0;
    mem_read_data     = '0;
    mem_ready         = 1'b0;

    edge_step();
    edge_step();
    settle();
    check_zero("reset");
    rst_n = 1'b1;

    // Single read with two wait cycles
    edge_step();
    set_port(1, 32'h0000_1000, 32'h0, 4'hF, 1'b0);
    port_request[1] = 1'b1;
    settle();
    chk("t1_idle_mem_request", 32'(mem_request), 32'd0);
    edge_step();
    settle();
    chk("t1_grant_valid", 32'(grant_valid), 32'd1);
    chk("t1_grant_id", 32'(grant_id), 32'd1);
    chk("t1_mem_request", 32'(mem_request), 32'd1);
    chk("t1_mem_address", mem_address, 32'h0000_1000);
    chk("t1_mem_we", 32'(mem_write_enable), 32'd0);
    chk("t1_wait1_ready", 32'(port_ready), 32'd0);
    edge_step();
    settle();
    chk("t1_wait2_ready", 32'(port_ready), 32'd0);
    edge_step();
    beat(1, 32'h0000_1000);
    settle();
    edge_step();
    settle();
    chk("t1_ready_once", 32'(port_ready), 32'd0);
    chk("t1_still_request", 32'(mem_request), 32'd1);
    edge_step();
    port_request[1] = 1'b0;
    settle();
    chk("t1_release_mem_request", 32'(mem_request), 32'd0);
    edge_step();
    settle();
    chk("t1_idle_grant_valid", 32'(grant_valid), 32'd0);

    // 4-beat refill on port 1 while port 0 waits
    edge_step();
    set_port(1, 32'h0000_2000, 32'h0, 4'hF, 1'b0);
    port_request[1] = 1'b1;
    settle();
    for (int k = 0; k < 4; k++) begin
      edge_step();
      if (k == 0) begin
        set_port(0, 32'h0000_3000, 32'h0, 4'hF, 1'b0);
        port_request[0] = 1'b1;
      end
      set_port(1, 32'h0000_2000 + 32'(4 * k), 32'h0, 4'hF, 1'b0);
      beat(1, 32'h0000_2000 + 32'(4 * k));
      settle();
      chk("t2_grant_id", 32'(grant_id), 32'd1);
      chk("t2_p0_ready", 32'(port_ready[0]), 32'd0);
    end
    edge_step();
    port_request[1] = 1'b0;
    settle();
    chk("t2_release_mem_request", 32'(mem_request), 32'd0);
    edge_step();
    settle();
    chk("t2_idle_grant_valid", 32'(grant_valid), 32'd0);
    chk("t2_idle_mem_request", 32'(mem_request), 32'd0);
    edge_step();
    beat(0, 32'h0000_3000);
    settle();
    chk("t2_p0_grant_id", 32'(grant_id), 32'd0);
    chk("t2_p0_mem_request", 32'(mem_request), 32'd1);
    edge_step();
    port_request[0] = 1'b0;
    settle();
    chk("t2_p0_release", 32'(mem_request), 32'd0);

    // Round-robin from reset with all ports requesting
    edge_step();
    for (int p = 0; p < NP; p++) set_port(p, 32'h0000_4000 + 32'(p * 256), 32'h0, 4'hF, 1'b0);
    port_request = '1;
    rst_n = 1'b0;
    settle();
    edge_step();
    settle();
    check_zero("t3_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      edge_step();
      beat(k % NP, 32'h0000_4000 + 32'((k % NP) * 256));
      settle();
      chk("t3_grant_id", 32'(grant_id), 32'(k % NP));
      chk("t3_grant_valid", 32'(grant_valid), 32'd1);
      edge_step();
      port_request[k % NP] = 1'b0;
      settle();
      chk("t3_release", 32'(mem_request), 32'd0);
      edge_step();
      port_request[k % NP] = 1'b1;
      settle();
      chk("t3_idle", 32'(grant_valid), 32'd0);
    end
    port_request = '0;

    // Write-through on port 3
    edge_step();
    set_port(3, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    port_request[3] = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) begin
      edge_step();
      if (k == 1) beat(3, 32'h0000_0040);
      settle();
      chk("t4_grant_id", 32'(grant_id), 32'd3);
      chk("t4_mem_address", mem_address, 32'h0000_0040);
      chk("t4_mem_wdata", mem_write_data, 32'hDEAD_BEEF);
      chk("t4_mem_be", 32'(mem_byte_enable), 32'h3);
      chk("t4_mem_we", 32'(mem_write_enable), 32'd1);
    end
    edge_step();
    port_request[3] = 1'b0;
    settle();
    chk("t4_release_we", 32'(mem_write_enable), 32'd0);
    chk("t4_release_wdata", mem_write_data, 32'd0);
    set_port(3, 32'h0, 32'h0, 4'h0, 1'b0);

    // A port 1 transaction advances the pointer to 2 before the reset test
    edge_step();
    set_port(1, 32'h0000_6000, 32'h0, 4'hF, 1'b0);
    port_request[1] = 1'b1;
    settle();
    edge_step();
    beat(1, 32'h0000_6000);
    settle();
    chk("t5_pre_grant_id", 32'(grant_id), 32'd1);
    edge_step();
    port_request[1] = 1'b0;
    settle();

    // Reset in the middle of port 2's refill
    edge_step();
    set_port(2, 32'h0000_5000, 32'h0, 4'hF, 1'b0);
    port_request[2] = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) begin
      edge_step();
      set_port(2, 32'h0000_5000 + 32'(4 * k), 32'h0, 4'hF, 1'b0);
      beat(2, 32'h0000_5000 + 32'(4 * k));
      settle();
      chk("t5_grant_id", 32'(grant_id), 32'd2);
    end
    edge_step();
    set_port(2, 32'h0000_5008, 32'h0, 4'hF, 1'b0);
    set_port(1, 32'h0000_7000, 32'h0, 4'hF, 1'b0);
    port_request[1] = 1'b1;
    rst_n = 1'b0;
    settle();
    chk("t5_pre_reset_request", 32'(mem_request), 32'd1);
    edge_step();
    settle();
    check_zero("t5_reset");
    rst_n = 1'b1;
    edge_step();
    settle();
    chk("t5_restart_grant_id", 32'(grant_id), 32'd1);
    chk("t5_restart_address", mem_address, 32'h0000_7000);
    edge_step();
    port_request = '0;
    settle();
    chk("t5_release", 32'(mem_request), 32'd0);

    // No requests for 20 cycles
    for (int k = 0; k < 20; k++) begin
      edge_step();
      settle();
      chk("idle_mem_request", 32'(mem_request), 32'd0);
      chk("idle_grant_valid", 32'(grant_valid), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
